// File: rtl/motion_pkg.sv
// Shared encoding and default timing for the motion arbiter.
package motion_pkg;

    localparam int unsigned STATE_W            = 3;
    localparam int unsigned CNT_W_DEF          = 20;
    localparam int unsigned AVOID_TICKS_DEF    = 500000;
    localparam int unsigned CMD_HOLD_TICKS_DEF = 100000;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_LEFT  = 3'd2,
        S_RIGHT = 3'd3,
        S_AVOID = 3'd4
    } motionState_e;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter stepping on tick, saturating at zero; load beats tick.
module tick_timer
    import motion_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (tick && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/motion_arbiter.sv
// Drive-command arbiter: obstacle avoidance over IR commands over hold timeout.
// Optional DARK_STOP_EN: forward motion is blocked while the room is dark.
module motion_arbiter
    import motion_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned AVOID_TICKS    = AVOID_TICKS_DEF,
    parameter int unsigned CMD_HOLD_TICKS = CMD_HOLD_TICKS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               ir_fwd,
    input  logic               ir_left,
    input  logic               ir_right,
    input  logic               too_close,
    input  logic               is_dark,
    output logic               fwd,
    output logic               turn_left,
    output logic               turn_right,
    output logic               avoiding,
    output logic               sound_on,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] AVOID_LOAD = CNT_W'(AVOID_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CMD_HOLD_TICKS - 1);

    motionState_e     stateQ;
    motionState_e     nextState;
    logic             timerLoad;
    logic [CNT_W-1:0] timerLoadVal;
    logic [CNT_W-1:0] timerCount;
    logic             timerZero;
    logic [1:0]       irCount;
    logic             cmdValid;
    logic             cmdConflict;

    assign irCount     = {1'b0, ir_fwd} + {1'b0, ir_left} + {1'b0, ir_right};
    assign cmdValid    = (irCount == 2'd1);
    assign cmdConflict = (irCount > 2'd1);

    tick_timer #(
        .CNT_W (CNT_W)
    ) uTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .load    (timerLoad),
        .loadVal (timerLoadVal),
        .count   (timerCount),
        .zero    (timerZero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ     <= S_IDLE;
            fwd        <= 1'b0;
            turn_left  <= 1'b0;
            turn_right <= 1'b0;
            avoiding   <= 1'b0;
            sound_on   <= 1'b0;
        end else begin
            stateQ     <= nextState;
            fwd        <= (nextState == S_FWD);
            turn_left  <= (nextState == S_LEFT);
            turn_right <= (nextState == S_RIGHT) || (nextState == S_AVOID);
            avoiding   <= (nextState == S_AVOID);
            sound_on   <= (nextState == S_AVOID) || is_dark;
        end
    end

    assign state_o = stateQ;

    always_comb begin
        nextState    = stateQ;
        timerLoad    = 1'b0;
        timerLoadVal = HOLD_LOAD;

        if (too_close && (stateQ != S_AVOID)) begin
            nextState    = S_AVOID;
            timerLoad    = 1'b1;
            timerLoadVal = AVOID_LOAD;
        end else if (stateQ == S_AVOID) begin
            // IR is ignored here; a persisting obstacle re-arms the turn
            if (tick && timerZero) begin
                if (too_close) begin
                    timerLoad    = 1'b1;
                    timerLoadVal = AVOID_LOAD;
                end else begin
                    nextState = S_IDLE;
                end
            end
        end else if (cmdValid) begin
            timerLoad = 1'b1;
            if (ir_fwd) begin
                nextState = S_FWD;
            end else if (ir_left) begin
                nextState = S_LEFT;
            end else begin
                nextState = S_RIGHT;
            end
        end else if (cmdConflict) begin
            nextState = S_IDLE;
        end else if (tick && timerZero) begin
            nextState = S_IDLE;
        end

`ifdef DARK_STOP_EN
        if ((nextState == S_FWD) && is_dark) begin
            nextState = S_IDLE;
        end
`else
        nextState = nextState;
`endif
    end

    // The shared counter never exceeds the avoid reload while avoiding.
    always_ff @(posedge clk) begin
        if (rst_n && (stateQ == S_AVOID)) begin
            assert (timerCount < CNT_W'(AVOID_TICKS));
        end
    end

endmodule

// File: tb/tb_motion_arbiter.sv
// Randomized and directed checks of motion_arbiter against a cycle-level behavioural model.
module tb_motion_arbiter;

    localparam int unsigned CNT_W = 20;
    localparam int AVOID = 8;
    localparam int HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       ir_fwd = 1'b0;
    logic       ir_left = 1'b0;
    logic       ir_right = 1'b0;
    logic       too_close = 1'b0;
    logic       is_dark = 1'b0;
    logic       fwd;
    logic       turn_left;
    logic       turn_right;
    logic       avoiding;
    logic       sound_on;
    logic [2:0] state_o;

    int   errors = 0;
    int   checks = 0;
    int   mState = 0;
    int   mCnt = 0;
    bit   tickPhase = 1'b0;
    bit   darkEn;

    motion_arbiter #(
        .CNT_W          (CNT_W),
        .AVOID_TICKS    (AVOID),
        .CMD_HOLD_TICKS (HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .ir_fwd     (ir_fwd),
        .ir_left    (ir_left),
        .ir_right   (ir_right),
        .too_close  (too_close),
        .is_dark    (is_dark),
        .fwd        (fwd),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .avoiding   (avoiding),
        .sound_on   (sound_on),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Abstract model: mode number plus remaining ticks, advanced once per clock.
    task automatic modelStep();
        int nIr;
        int ns;
        if (!rst_n) begin
            mState = 0;
            mCnt   = 0;
            return;
        end
        nIr = int'(ir_fwd) + int'(ir_left) + int'(ir_right);
        ns  = mState;
        if (too_close && mState != 4) begin
            ns   = 4;
            mCnt = AVOID - 1;
        end else if (mState == 4) begin
            if (tick) begin
                if (mCnt > 0) mCnt--;
                else if (too_close) mCnt = AVOID - 1;
                else ns = 0;
            end
        end else if (nIr == 1) begin
            ns   = ir_fwd ? 1 : (ir_left ? 2 : 3);
            mCnt = HOLD - 1;
        end else begin
            if (nIr > 1) ns = 0;
            if (tick) begin
                if (mCnt > 0) mCnt--;
                else ns = 0;
            end
        end
        if (darkEn && ns == 1 && is_dark) ns = 0;
        mState = ns;
    endtask

    task automatic applyCycle(input logic r, input logic f, input logic l, input logic rt,
                              input logic tc, input logic dk);
        logic [4:0] expOut;
        logic [4:0] gotOut;
        rst_n     = r;
        ir_fwd    = f;
        ir_left   = l;
        ir_right  = rt;
        too_close = tc;
        is_dark   = dk;
        tick      = tickPhase;
        tickPhase = ~tickPhase;
        @(posedge clk);
        modelStep();
        #1;
        if (!r) expOut = 5'b0;
        else expOut = {mState == 1, mState == 2, mState == 3 || mState == 4,
                       mState == 4, mState == 4 || dk};
        gotOut = {fwd, turn_left, turn_right, avoiding, sound_on};
        checkVal("state", 32'(state_o), 32'(mState));
        checkVal("outs", 32'(gotOut), 32'(expOut));
        checkVal("driveOneHot", 32'($countones({fwd, turn_left, turn_right}) <= 1), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyCycle(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
`ifdef DARK_STOP_EN
        darkEn = 1'b1;
`else
        darkEn = 1'b0;
`endif
        @(negedge clk);

        // reset with active requests, then obstacle takes over on release
        for (int i = 0; i < 3; i++) applyCycle(0, 1, 0, 0, 1, 0);
        checkVal("resetState", 32'(state_o), 32'd0);
        applyCycle(1, 1, 0, 0, 1, 0);
        checkVal("releaseAvoid", 32'(avoiding), 32'd1);
        idle(24);

        // single-clock IR pulse held by the timer
        applyCycle(1, 0, 1, 0, 0, 0);
        checkVal("leftPulse", 32'(turn_left), 32'd1);
        idle(12);
        checkVal("leftExpired", 32'(state_o), 32'd0);

        // obstacle preempts forward; IR ignored during avoid
        applyCycle(1, 1, 0, 0, 0, 0);
        applyCycle(1, 1, 0, 0, 0, 0);
        applyCycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) applyCycle(1, 0, 1, 0, 0, 0);
        idle(16);

        // sustained obstacle
        for (int i = 0; i < 40; i++) applyCycle(1, 0, 0, 0, 1, 0);
        checkVal("sustainAvoid", 32'(avoiding), 32'd1);
        idle(20);

        // conflict, then direct switch
        applyCycle(1, 1, 0, 1, 0, 0);
        checkVal("conflictIdle", 32'(state_o), 32'd0);
        applyCycle(1, 1, 0, 0, 0, 0);
        applyCycle(1, 1, 0, 0, 0, 0);
        applyCycle(1, 0, 0, 1, 0, 0);
        checkVal("switchRight", 32'(turn_right), 32'd1);
        idle(10);

        // darkness with forward request
        for (int i = 0; i < 3; i++) applyCycle(1, 1, 0, 0, 0, 1);
        checkVal("darkSound", 32'(sound_on), 32'd1);
        checkVal("darkFwd", 32'(fwd), darkEn ? 32'd0 : 32'd1);
        applyCycle(1, 0, 0, 0, 0, 1);
        idle(10);

        // randomized traffic, inputs held for random stretches
        begin
            logic [5:0] v;
            v = 6'b100000;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(3) == 0) begin
                    v[5] = ($urandom_range(99) != 0);
                    v[4] = ($urandom_range(2) == 0);
                    v[3] = ($urandom_range(3) == 0);
                    v[2] = ($urandom_range(3) == 0);
                    v[1] = ($urandom_range(14) == 0);
                    v[0] = ($urandom_range(2) == 0);
                end
                if (v[1] && $urandom_range(1) == 0) v[1] = 1'b0;
                applyCycle(v[5], v[4], v[3], v[2], v[1], v[0]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
